// File: rtl/ysyx_22041071_id_operand_stage.sv
// ============================================================================
// Module   : ysyx_22041071_id_operand_stage
// Function : Decode-side operand stage with register file, priority forwarding,
//            load-use stall and valid/ready output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22041071_id_operand_stage #(
    parameter int XLEN      = 64,
    parameter int NREG      = 32,
    parameter int AW        = 5,
    parameter int NRD       = 2,
    parameter int NFWD      = 3,
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NRD*AW-1:0]      in_rs,
    input  logic [NRD-1:0]         in_rs_use,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic                   flush,
    input  logic [NFWD-1:0]        fwd_wen,
    input  logic [NFWD-1:0]        fwd_load,
    input  logic [NFWD*AW-1:0]     fwd_rd,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic                   wb_wen,
    input  logic [AW-1:0]          wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NRD*XLEN-1:0]    out_src,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [CNT_W-1:0]       stall_cnt,
    input  logic [AW-1:0]          dbg_raddr,
    output logic [XLEN-1:0]        dbg_rdata
);

    logic [XLEN-1:0]      r_regs [NREG];
    logic                 r_out_valid;
    logic [NRD*XLEN-1:0]  r_out_src;
    logic [PAYLOAD_W-1:0] r_out_payload;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [NRD*XLEN-1:0]  w_src;
    logic [NRD-1:0]       w_fwd_hit;
    logic                 w_load_use;
    logic                 w_accept;
    logic                 w_unused_fwd_load;

    // Only the EX-stage load is still in flight; older loads already have data.
    assign w_unused_fwd_load = ^fwd_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else if (wb_wen && (wb_rd != '0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    assign dbg_rdata = (dbg_raddr == '0) ? '0 : r_regs[dbg_raddr];

    always_comb begin
        w_src     = '0;
        w_fwd_hit = '0;
        for (int j = 0; j < NRD; j++) begin
            if (in_rs[j*AW +: AW] != '0) begin
                for (int i = 0; i < NFWD; i++) begin
                    if (!w_fwd_hit[j] && fwd_wen[i] &&
                        (fwd_rd[i*AW +: AW] == in_rs[j*AW +: AW])) begin
                        w_src[j*XLEN +: XLEN] = fwd_data[i*XLEN +: XLEN];
                        w_fwd_hit[j]          = 1'b1;
                    end
                end
                if (!w_fwd_hit[j]) begin
                    if (wb_wen && (wb_rd == in_rs[j*AW +: AW])) begin
                        w_src[j*XLEN +: XLEN] = wb_data;
                    end else begin
                        w_src[j*XLEN +: XLEN] = r_regs[in_rs[j*AW +: AW]];
                    end
                end
            end
        end
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int j = 0; j < NRD; j++) begin
            if (in_rs_use[j] && (in_rs[j*AW +: AW] != '0) && fwd_wen[0] &&
                fwd_load[0] && (fwd_rd[0 +: AW] == in_rs[j*AW +: AW])) begin
                w_load_use = 1'b1;
            end
        end
        w_load_use = w_load_use & in_valid;
    end

    assign in_ready = !flush && !w_load_use && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_src     <= '0;
            r_out_payload <= '0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_src     <= w_src;
            r_out_payload <= in_payload;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_load_use && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid   = r_out_valid;
    assign out_src     = r_out_src;
    assign out_payload = r_out_payload;
    assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041071_id_operand_stage.sv
// ============================================================================
// Module   : tb_ysyx_22041071_id_operand_stage
// Function : Directed self-checking bench for the decode operand stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22041071_id_operand_stage;

    localparam int XLEN = 64, NREG = 32, AW = 5, NRD = 2, NFWD = 3, PW = 128, CW = 32;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NRD*AW-1:0] in_rs;
    logic [NRD-1:0]    in_rs_use;
    logic [PW-1:0]     in_payload;
    logic              flush;
    logic [NFWD-1:0]   fwd_wen;
    logic [NFWD-1:0]   fwd_load;
    logic [NFWD*AW-1:0]   fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic              wb_wen;
    logic [AW-1:0]     wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [NRD*XLEN-1:0] out_src;
    logic [PW-1:0]     out_payload;
    logic [CW-1:0]     stall_cnt;
    logic [AW-1:0]     dbg_raddr;
    logic [XLEN-1:0]   dbg_rdata;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_22041071_id_operand_stage #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NFWD(NFWD),
        .PAYLOAD_W(PW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rs_use(in_rs_use), .in_payload(in_payload),
        .flush(flush), .fwd_wen(fwd_wen), .fwd_load(fwd_load), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_payload(out_payload), .stall_cnt(stall_cnt),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        fwd_rd[i*AW +: AW]       = rd;
        fwd_data[i*XLEN +: XLEN] = d;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_rs = '0; in_rs_use = '0; in_payload = '0;
        flush = 1'b0; fwd_wen = '0; fwd_load = '0; fwd_rd = '0; fwd_data = '0;
        wb_wen = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1; dbg_raddr = '0;
        tick(); tick();
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_stall_cnt", {96'd0, stall_cnt}, 128'd0);
        reset = 1'b1;
        tick();

        // writeback then read through a later accept
        wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
        tick();
        wb_wen = 1'b0;
        dbg_raddr = 5'd5;
        in_valid = 1'b1; in_rs = {5'd0, 5'd5}; in_payload = 128'hA1;
        #1;
        chk("dbg_x5", {64'd0, dbg_rdata}, 128'h1234);
        chk("ready_idle", {127'd0, in_ready}, 128'd1);
        tick();
        chk("wb_out_valid", {127'd0, out_valid}, 128'd1);
        chk("wb_src0", {64'd0, out_src[63:0]}, 128'h1234);
        chk("wb_src1_x0", {64'd0, out_src[127:64]}, 128'd0);
        chk("wb_payload", out_payload, 128'hA1);

        // same-cycle writeback bypass, plus write to x0 ignored
        wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
        in_rs = {5'd0, 5'd9}; in_payload = 128'hA2;
        tick();
        chk("bypass_src0", {64'd0, out_src[63:0]}, 128'h99);
        wb_rd = 5'd0; wb_data = 64'hFFFF; in_valid = 1'b0;
        tick();
        wb_wen = 1'b0; dbg_raddr = 5'd0;
        #1;
        chk("dbg_x0", {64'd0, dbg_rdata}, 128'd0);
        chk("bubble_valid", {127'd0, out_valid}, 128'd0);

        // forwarding priority: EX over oldest over writeback
        wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 64'hC;
        fwd_wen = 3'b101; set_fwd(0, 5'd7, 64'hA); set_fwd(2, 5'd7, 64'hB);
        in_valid = 1'b1; in_rs = {5'd7, 5'd0}; in_payload = 128'hA3;
        tick();
        chk("fwd_ex", {64'd0, out_src[127:64]}, 128'hA);
        wb_wen = 1'b0; fwd_wen = 3'b100;
        tick();
        chk("fwd_old", {64'd0, out_src[127:64]}, 128'hB);
        fwd_wen = 3'b000;
        tick();
        chk("fwd_none_reg", {64'd0, out_src[127:64]}, 128'hC);

        // load-use stall on EX-stage load
        fwd_wen = 3'b001; fwd_load = 3'b001; set_fwd(0, 5'd3, 64'h33);
        in_rs = {5'd0, 5'd3}; in_rs_use = 2'b01; in_payload = 128'hA4;
        #1;
        chk("lu_ready", {127'd0, in_ready}, 128'd0);
        tick();
        chk("lu_bubble", {127'd0, out_valid}, 128'd0);
        chk("lu_cnt1", {96'd0, stall_cnt}, 128'd1);
        chk("lu_payload_held", out_payload, 128'hA3);
        in_rs_use = 2'b00;
        #1;
        chk("nouse_ready", {127'd0, in_ready}, 128'd1);
        tick();
        chk("nouse_valid", {127'd0, out_valid}, 128'd1);
        chk("nouse_src0", {64'd0, out_src[63:0]}, 128'h33);
        chk("nouse_cnt", {96'd0, stall_cnt}, 128'd1);
        // a load in an older stage forwards without stalling
        fwd_wen = 3'b100; fwd_load = 3'b100; set_fwd(2, 5'd3, 64'h44);
        set_fwd(0, 5'd0, 64'h0); in_rs_use = 2'b01; in_payload = 128'hA5;
        #1;
        chk("oldload_ready", {127'd0, in_ready}, 128'd1);
        tick();
        chk("oldload_src0", {64'd0, out_src[63:0]}, 128'h44);
        fwd_wen = '0; fwd_load = '0; in_rs_use = '0;

        // backpressure hold
        out_ready = 1'b0; in_payload = 128'hA6; in_rs = {5'd5, 5'd9};
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", {127'd0, in_ready}, 128'd0);
            tick();
            chk("bp_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_payload", out_payload, 128'hA5);
            chk("bp_src0", {64'd0, out_src[63:0]}, 128'h44);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_ready", {127'd0, in_ready}, 128'd1);
        tick();
        chk("drain_payload", out_payload, 128'hA6);
        chk("drain_src", out_src, {64'h1234, 64'h99});

        // flush kills held instruction without capture
        flush = 1'b1; in_payload = 128'hA7;
        #1;
        chk("flush_ready", {127'd0, in_ready}, 128'd0);
        tick();
        chk("flush_valid", {127'd0, out_valid}, 128'd0);
        chk("flush_payload", out_payload, 128'hA6);
        // flush with load-use: stall still counted
        fwd_wen = 3'b001; fwd_load = 3'b001; set_fwd(0, 5'd9, 64'h1);
        in_rs_use = 2'b01;
        tick();
        chk("flush_lu_cnt", {96'd0, stall_cnt}, 128'd2);
        chk("flush_lu_valid", {127'd0, out_valid}, 128'd0);
        flush = 1'b0; fwd_wen = '0; fwd_load = '0; in_rs_use = '0;
        in_payload = 128'hA8;
        tick();
        chk("pre_rst_valid", {127'd0, out_valid}, 128'd1);

        // asynchronous reset mid-traffic
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_cnt", {96'd0, stall_cnt}, 128'd0);
        chk("arst_payload", out_payload, 128'd0);
        chk("arst_src", out_src, 128'd0);
        for (int r = 0; r < NREG; r++) begin
            dbg_raddr = AW'(r);
            #1;
            chk("arst_reg", {64'd0, dbg_rdata}, 128'd0);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_valid", {127'd0, out_valid}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
